// File: rtl/uart_seg_mux_display_pkg.sv
// Shared constants and helpers for the multi-digit UART-to-7-segment display.
// Holds the digit codes, the control bytes and the segment patterns.
package uart_seg_mux_display_pkg;

    localparam logic [4:0] CODE_BLANK = 5'd16;
    localparam logic [4:0] CODE_DASH  = 5'd17;

    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] ESC = 8'h1B;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;

    // Active-high patterns, bit6 = a ... bit0 = g
    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b0000001;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_PUSH,
        ACT_BACK,
        ACT_CLEAR
    } byte_action_e;

    // Returns {valid, code}; letters only count as digits when hex_en is set.
    function automatic logic [5:0] decode_char(input logic [7:0] b, input logic hex_en);
        logic [5:0] r;
        r = {1'b0, CODE_DASH};
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, 5'(b - 8'h30)};
        else if (hex_en && b >= 8'h41 && b <= 8'h46)
            r = {1'b1, 5'(b - 8'h37)};
        else if (hex_en && b >= 8'h61 && b <= 8'h66)
            r = {1'b1, 5'(b - 8'h57)};
        return r;
    endfunction

endpackage

// File: rtl/uart_seg_mux_display_seg7_encode.sv
// Combinational 5-bit digit code to active-high 7-segment pattern.
module seg7_encode
    import uart_seg_mux_display_pkg::*;
(
    input  logic [4:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            5'd0:       pattern = SEG_0;
            5'd1:       pattern = SEG_1;
            5'd2:       pattern = SEG_2;
            5'd3:       pattern = SEG_3;
            5'd4:       pattern = SEG_4;
            5'd5:       pattern = SEG_5;
            5'd6:       pattern = SEG_6;
            5'd7:       pattern = SEG_7;
            5'd8:       pattern = SEG_8;
            5'd9:       pattern = SEG_9;
            5'd10:      pattern = SEG_A;
            5'd11:      pattern = SEG_B;
            5'd12:      pattern = SEG_C;
            5'd13:      pattern = SEG_D;
            5'd14:      pattern = SEG_E;
            5'd15:      pattern = SEG_F;
            CODE_DASH:  pattern = SEG_DASH;
            default:    pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/uart_seg_mux_display.sv
// Shifts received characters into an NDIG-digit buffer and scans it onto a
// shared segment bus with one-hot digit enables.
module uart_seg_mux_display
    import uart_seg_mux_display_pkg::*;
#(
    parameter int NDIG           = 4,
    parameter int REFRESH_DIV    = 12000,
    parameter int HEX_EN         = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [7:0]      rxbyte,
    input  logic            received,
    output logic [6:0]      seg,
    output logic [NDIG-1:0] dig,
    output logic            bad_char
);

    localparam int   DIV_W   = $clog2(REFRESH_DIV);
    localparam int   IDX_W   = $clog2(NDIG);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic DIG_INV = (DIG_ACTIVE_LOW != 0);
    localparam logic HEX_ON  = (HEX_EN != 0);

    logic [NDIG-1:0][4:0] buffer;
    logic [DIV_W-1:0]     div_cnt;
    logic [IDX_W-1:0]     scan_idx;
    logic [6:0]           enc_pattern;
    logic [NDIG-1:0]      onehot;
    logic [5:0]           decoded;
    byte_action_e         action;
    logic [4:0]           push_code;
    logic                 set_bad;

    // Classify the incoming byte into one buffer action
    always_comb begin
        decoded   = decode_char(rxbyte, HEX_ON);
        action    = ACT_NONE;
        push_code = CODE_DASH;
        set_bad   = 1'b0;
        if (received) begin
            if (decoded[5]) begin
                action    = ACT_PUSH;
                push_code = decoded[4:0];
            end else begin
                case (rxbyte)
                    BS:      action = ACT_BACK;
                    ESC:     action = ACT_CLEAR;
                    CR, LF:  action = ACT_NONE;
                    default: begin
                        action  = ACT_PUSH;
                        set_bad = 1'b1;
                    end
                endcase
            end
        end
    end

    seg7_encode u_encode (
        .code    (buffer[scan_idx]),
        .pattern (enc_pattern)
    );

    assign onehot = NDIG'(1) << scan_idx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            buffer   <= {NDIG{CODE_BLANK}};
            div_cnt  <= '0;
            scan_idx <= '0;
            bad_char <= 1'b0;
            seg      <= {7{SEG_INV}};
            dig      <= {NDIG{DIG_INV}};
        end else begin
            seg <= enc_pattern ^ {7{SEG_INV}};
            dig <= onehot ^ {NDIG{DIG_INV}};

            if (div_cnt == DIV_W'(REFRESH_DIV - 1)) begin
                div_cnt  <= '0;
                scan_idx <= (scan_idx == IDX_W'(NDIG - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            case (action)
                ACT_PUSH:  buffer <= {buffer[NDIG-2:0], push_code};
                ACT_BACK:  buffer <= {CODE_BLANK, buffer[NDIG-1:1]};
                ACT_CLEAR: buffer <= {NDIG{CODE_BLANK}};
                default:   buffer <= buffer;
            endcase

            // ESC clears the sticky flag; an invalid byte sets it
            if (action == ACT_CLEAR)
                bad_char <= 1'b0;
            else if (set_bad)
                bad_char <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_seg_mux_display.sv
// Self-checking bench: two display instances (decimal/active-high and
// hex/active-low) share one stimulus and are compared with a buffer model.
module tb_uart_seg_mux_display;

    localparam int RD = 4;
    localparam int ND = 4;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rxbyte = 8'h00;
    logic       received = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic [3:0] dig_a, dig_b;
    logic       bad_a, bad_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_seg_mux_display #(
        .NDIG(ND), .REFRESH_DIV(RD), .HEX_EN(0), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .resetn(resetn), .rxbyte(rxbyte), .received(received),
        .seg(seg_a), .dig(dig_a), .bad_char(bad_a)
    );

    uart_seg_mux_display #(
        .NDIG(ND), .REFRESH_DIV(RD), .HEX_EN(1), .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .resetn(resetn), .rxbyte(rxbyte), .received(received),
        .seg(seg_b), .dig(dig_b), .bad_char(bad_b)
    );

    // Reference model: buffer of character codes (16 blank, 17 dash) plus an
    // edge count since reset from which the scanned digit is derived.
    int         m_edges;
    int         m_buf [2][ND];
    bit         m_bad [2];
    logic [6:0] m_seg [2];
    logic [3:0] m_dig [2];

    function automatic logic [6:0] spec_pattern(input int code);
        case (code)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            15: return 7'b1000111;
            17: return 7'b0000001;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int char_value(input logic [7:0] b, input bit hex);
        if (b >= "0" && b <= "9") return int'(b) - 48;
        if (hex && b >= "A" && b <= "F") return int'(b) - 55;
        if (hex && b >= "a" && b <= "f") return int'(b) - 87;
        return -1;
    endfunction

    function automatic void model_byte(input int m, input logic [7:0] b);
        int v;
        v = char_value(b, m == 1);
        if (b == 8'h1B) begin
            for (int i = 0; i < ND; i++) m_buf[m][i] = 16;
            m_bad[m] = 1'b0;
        end else if (b == 8'h0D || b == 8'h0A) begin
        end else if (b == 8'h08) begin
            for (int i = 0; i < ND - 1; i++) m_buf[m][i] = m_buf[m][i+1];
            m_buf[m][ND-1] = 16;
        end else begin
            for (int i = ND - 1; i > 0; i--) m_buf[m][i] = m_buf[m][i-1];
            m_buf[m][0] = (v >= 0) ? v : 17;
            if (v < 0) m_bad[m] = 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        if (!resetn) begin
            m_edges = 0;
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < ND; i++) m_buf[m][i] = 16;
                m_bad[m] = 1'b0;
            end
            m_seg[0] = 7'h00; m_dig[0] = 4'h0;
            m_seg[1] = 7'h7F; m_dig[1] = 4'hF;
        end else begin
            for (int m = 0; m < 2; m++) begin
                int slot;
                slot = (m_edges / RD) % ND;
                m_seg[m] = (m == 1) ? ~spec_pattern(m_buf[m][slot]) : spec_pattern(m_buf[m][slot]);
                m_dig[m] = (m == 1) ? ~(4'b0001 << slot) : (4'b0001 << slot);
                if (received) model_byte(m, rxbyte);
            end
            m_edges++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rxbyte   = b;
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_dig_a(input logic [3:0] target, output bit found);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (dig_a == target) found = 1'b1;
        end
    endtask

    task automatic wait_dig_b(input logic [3:0] target, output bit found);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (dig_b == target) found = 1'b1;
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (seg_a !== 7'h00 || dig_a !== 4'h0 || bad_a !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_a: seg=%b dig=%b bad=%b required 0000000 0000 0", seg_a, dig_a, bad_a);
        end
        n_checks++;
        if (seg_b !== 7'h7F || dig_b !== 4'hF || bad_b !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_b: seg=%b dig=%b bad=%b required 1111111 1111 0", seg_b, dig_b, bad_b);
        end
        resetn = 1'b1;
    endtask

    task automatic test_idle;
        logic [3:0] prev;
        int held;
        prev = 4'h0;
        held = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            n_checks++;
            if (seg_a !== m_seg[0] || dig_a !== m_dig[0] || bad_a !== m_bad[0]) begin
                n_fail++;
                $display("[TB] FAIL idle_a cyc %0d: seg=%b dig=%b bad=%b required %b %b %b",
                         c, seg_a, dig_a, bad_a, m_seg[0], m_dig[0], m_bad[0]);
            end
            n_checks++;
            if (seg_a !== 7'h00) begin
                n_fail++;
                $display("[TB] FAIL idle_blank cyc %0d: seg=%b required 0000000", c, seg_a);
            end
            if (dig_a !== prev && c > 0) begin
                n_checks++;
                if (held != RD || dig_a !== {prev[2:0], prev[3]}) begin
                    n_fail++;
                    $display("[TB] FAIL idle_slot cyc %0d: dig=%b after %0d cycles of %b, required %0d cycles then rotate",
                             c, dig_a, held, prev, RD);
                end
                held = 0;
            end
            prev = dig_a;
            held++;
        end
    endtask

    task automatic test_digits;
        logic [3:0] tgt  [4];
        logic [6:0] want [4];
        bit found;
        send_byte("1"); send_byte("2"); send_byte("3");
        tgt[0] = 4'b0001; want[0] = 7'b1111001;
        tgt[1] = 4'b0010; want[1] = 7'b1101101;
        tgt[2] = 4'b0100; want[2] = 7'b0110000;
        tgt[3] = 4'b1000; want[3] = 7'b0000000;
        for (int j = 0; j < 4; j++) begin
            wait_dig_a(tgt[j], found);
            n_checks++;
            if (!found || seg_a !== want[j]) begin
                n_fail++;
                $display("[TB] FAIL digits_123 dig %b: found=%0d seg=%b required %b", tgt[j], found, seg_a, want[j]);
            end
        end
        send_byte("1"); send_byte("2"); send_byte("3"); send_byte("4"); send_byte("5");
        wait_dig_a(4'b1000, found);
        n_checks++;
        if (!found || seg_a !== 7'b1101101) begin
            n_fail++;
            $display("[TB] FAIL wrap_top: found=%0d seg=%b required 1101101", found, seg_a);
        end
        wait_dig_a(4'b0001, found);
        n_checks++;
        if (!found || seg_a !== 7'b1011011) begin
            n_fail++;
            $display("[TB] FAIL wrap_low: found=%0d seg=%b required 1011011", found, seg_a);
        end
    endtask

    task automatic test_control;
        bit found;
        send_byte("7"); send_byte("x");
        wait_dig_a(4'b0001, found);
        n_checks++;
        if (!found || seg_a !== 7'b0000001 || bad_a !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bad_dash: found=%0d seg=%b bad=%b required 0000001 1", found, seg_a, bad_a);
        end
        wait_dig_a(4'b0010, found);
        n_checks++;
        if (!found || seg_a !== 7'b1110000) begin
            n_fail++;
            $display("[TB] FAIL bad_prev: found=%0d seg=%b required 1110000", found, seg_a);
        end
        send_byte(8'h0D); send_byte(8'h08);
        wait_dig_a(4'b0001, found);
        n_checks++;
        if (!found || seg_a !== 7'b1110000 || bad_a !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL backspace: found=%0d seg=%b bad=%b required 1110000 1", found, seg_a, bad_a);
        end
        send_byte(8'h1B);
        for (int c = 0; c < RD * ND; c++) begin
            @(negedge clk);
            n_checks++;
            if (seg_a !== 7'h00 || bad_a !== 1'b0 || seg_b !== 7'h7F) begin
                n_fail++;
                $display("[TB] FAIL escape cyc %0d: seg_a=%b bad_a=%b seg_b=%b required 0000000 0 1111111",
                         c, seg_a, bad_a, seg_b);
            end
        end
    endtask

    task automatic test_hex_reset;
        bit found;
        send_byte("A");
        wait_dig_b(4'b1110, found);
        n_checks++;
        if (!found || seg_b !== 7'b0001000 || bad_b !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hex_lowactive: found=%0d seg=%b bad=%b required 0001000 0", found, seg_b, bad_b);
        end
        n_checks++;
        if (bad_a !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hex_disabled: bad_a=%b required 1", bad_a);
        end
        repeat (2) @(negedge clk);
        resetn   = 1'b0;
        rxbyte   = "9";
        received = 1'b1;
        @(negedge clk);
        received = 1'b0;
        resetn   = 1'b1;
        n_checks++;
        if (seg_b !== 7'h7F || dig_b !== 4'hF || seg_a !== 7'h00 || dig_a !== 4'h0 || bad_a !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midslot_reset: seg_b=%b dig_b=%b seg_a=%b dig_a=%b bad_a=%b required 1111111 1111 0000000 0000 0",
                     seg_b, dig_b, seg_a, dig_a, bad_a);
        end
        wait_dig_b(4'b1110, found);
        n_checks++;
        if (!found || seg_b !== 7'h7F) begin
            n_fail++;
            $display("[TB] FAIL reset_drop: found=%0d seg=%b required 1111111", found, seg_b);
        end
    endtask

    task automatic test_back_to_back;
        bit found;
        bit aligned;
        send_byte(8'h1B);
        aligned = 1'b0;
        for (int c = 0; c < 2 * RD && !aligned; c++) begin
            @(negedge clk);
            if (m_edges % RD == RD - 2) aligned = 1'b1;
        end
        rxbyte = "4"; received = 1'b1;
        @(negedge clk);
        rxbyte = "5";
        @(negedge clk);
        received = 1'b0;
        n_checks++;
        if (!aligned) begin
            n_fail++;
            $display("[TB] FAIL b2b_align: aligned=%0d required 1", aligned);
        end
        wait_dig_a(4'b0010, found);
        n_checks++;
        if (!found || seg_a !== 7'b0110011) begin
            n_fail++;
            $display("[TB] FAIL b2b_entry1: found=%0d seg=%b required 0110011", found, seg_a);
        end
        wait_dig_a(4'b0001, found);
        n_checks++;
        if (!found || seg_a !== 7'b1011011 || seg_b !== ~7'b1011011) begin
            n_fail++;
            $display("[TB] FAIL b2b_entry0: found=%0d seg_a=%b seg_b=%b required 1011011 0100100", found, seg_a, seg_b);
        end
    endtask

    task automatic test_random;
        int pick;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                logic [6:0] s;
                logic [3:0] d;
                logic       b;
                s = (m == 0) ? seg_a : seg_b;
                d = (m == 0) ? dig_a : dig_b;
                b = (m == 0) ? bad_a : bad_b;
                n_checks++;
                if (s !== m_seg[m] || d !== m_dig[m] || b !== m_bad[m]) begin
                    n_fail++;
                    $display("[TB] FAIL random dut%0d cyc %0d: seg=%b dig=%b bad=%b required %b %b %b",
                             m, c, s, d, b, m_seg[m], m_dig[m], m_bad[m]);
                end
            end
            resetn   = ($urandom_range(0, 79) != 0);
            received = ($urandom_range(0, 2) == 0);
            pick     = $urandom_range(0, 9);
            case (pick)
                0, 1, 2, 3, 4: rxbyte = 8'(48 + $urandom_range(0, 9));
                5:             rxbyte = $urandom_range(0, 1) ? 8'(65 + $urandom_range(0, 5))
                                                             : 8'(97 + $urandom_range(0, 5));
                6:             rxbyte = 8'h08;
                7:             rxbyte = 8'h1B;
                8:             rxbyte = $urandom_range(0, 1) ? 8'h0D : 8'h0A;
                default:       rxbyte = 8'($urandom_range(0, 255));
            endcase
        end
        @(negedge clk);
        received = 1'b0;
        resetn   = 1'b1;
    endtask

    initial begin
        test_reset();
        test_idle();
        test_digits();
        test_control();
        test_hex_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
